// File: rtl/pcie_pipe_pkg.sv
// Shared PIPE definitions for the RX and TX data blocks: generation codes,
// special symbols, sync header values and default per-generation widths.
package pcie_pipe_pkg;

  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_OS   = 2'b01;

  localparam int PIPE_WIDTH_GEN1 = 8;
  localparam int PIPE_WIDTH_GEN2 = 8;
  localparam int PIPE_WIDTH_GEN3 = 16;
  localparam int PIPE_WIDTH_GEN4 = 32;
  localparam int PIPE_WIDTH_GEN5 = 32;

  // Index of the last beat of a 32-bit word for a given PIPE width (N-1).
  function automatic logic [1:0] last_beat_of(input int width);
    case (width)
      8:       last_beat_of = 2'd3;
      16:      last_beat_of = 2'd1;
      default: last_beat_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_rx_byte_packer.sv
// Packs 8/16/32-bit PIPE beats into 32-bit words; flush and realign both
// restart the word so the current beat lands in lane group 0.
module pipe_rx_byte_packer
  import pcie_pipe_pkg::*;
(
  input  logic        pclk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        realign_i,
  input  logic        accept_i,
  input  logic [1:0]  last_beat_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  k_i,
  output logic        word_done_o,
  output logic [31:0] word_o,
  output logic [3:0]  word_k_o,
  output logic [1:0]  beat_cnt_o
);

  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  acc_k_q, acc_k_d;
  logic [1:0]  base_cnt;
  logic [31:0] merged;
  logic [3:0]  merged_k;
  logic        restart;

  always_comb begin
    restart  = flush_i || realign_i;
    base_cnt = restart ? 2'd0 : beat_cnt_q;
    merged   = restart ? 32'd0 : acc_q;
    merged_k = restart ? 4'd0 : acc_k_q;
    if (accept_i) begin
      case (last_beat_i)
        2'd3: begin
          merged[{base_cnt, 3'b000} +: 8] = data_i[7:0];
          merged_k[base_cnt]              = k_i[0];
        end
        2'd1: begin
          merged[{base_cnt[0], 4'b0000} +: 16] = data_i[15:0];
          merged_k[{base_cnt[0], 1'b0} +: 2]   = k_i[1:0];
        end
        default: begin
          merged   = data_i;
          merged_k = k_i;
        end
      endcase
    end
    word_done_o = accept_i && (base_cnt == last_beat_i);
    if (word_done_o) begin
      beat_cnt_d = 2'd0;
      acc_d      = 32'd0;
      acc_k_d    = 4'd0;
    end else begin
      beat_cnt_d = accept_i ? base_cnt + 2'd1 : base_cnt;
      acc_d      = merged;
      acc_k_d    = merged_k;
    end
  end

  assign word_o     = merged;
  assign word_k_o   = merged_k;
  assign beat_cnt_o = beat_cnt_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= 2'd0;
      acc_q      <= 32'd0;
      acc_k_q    <= 4'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
      acc_k_q    <= acc_k_d;
    end
  end

endmodule

// File: rtl/pipe_rx_data.sv
// Receive-side PIPE data path: qualifies PHY beats, realigns on COM or block
// start, and hands registered 32-bit words to the descrambler.
module pipe_rx_data
  import pcie_pipe_pkg::*;
#(
  parameter int pipe_width_gen1 = PIPE_WIDTH_GEN1,
  parameter int pipe_width_gen2 = PIPE_WIDTH_GEN2,
  parameter int pipe_width_gen3 = PIPE_WIDTH_GEN3,
  parameter int pipe_width_gen4 = PIPE_WIDTH_GEN4,
  parameter int pipe_width_gen5 = PIPE_WIDTH_GEN5
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  generation,
  input  logic [31:0] RxData,
  input  logic [3:0]  RxDataK,
  input  logic        RxValid,
  input  logic        RxDataValid,
  input  logic        RxStartBlock,
  input  logic [1:0]  RxSyncHeader,
  output logic [31:0] descramblerDataIn,
  output logic [3:0]  descramblerDataK,
  output logic        descramblerDataValid,
  output logic        descramblerStartBlock,
  output logic [1:0]  descramblerSyncHeader,
  output logic        alignErr
);

  logic [2:0]  gen_q;
  logic [1:0]  sync_hdr_q, sync_hdr_d;
  logic        sb_pend_q, sb_pend_d;
  logic [31:0] data_q;
  logic [3:0]  data_k_q;
  logic        valid_q, start_block_q, align_err_q;
  logic [1:0]  sync_out_q;

  logic        gen_ok, gen3p, is_com, accept, realign, flush;
  logic        sb_beat, word_sb, align_err_d;
  logic [1:0]  last_beat;
  logic        word_done;
  logic [31:0] word;
  logic [3:0]  word_k;
  logic [1:0]  beat_cnt;

  always_comb begin
    case (generation)
      GEN1:    last_beat = last_beat_of(pipe_width_gen1);
      GEN2:    last_beat = last_beat_of(pipe_width_gen2);
      GEN3:    last_beat = last_beat_of(pipe_width_gen3);
      GEN4:    last_beat = last_beat_of(pipe_width_gen4);
      GEN5:    last_beat = last_beat_of(pipe_width_gen5);
      default: last_beat = 2'd0;
    endcase
  end

  // Any flush (lock loss, speed change, bad speed) overrides realign error reporting.
  always_comb begin
    gen_ok      = (generation >= GEN1) && (generation <= GEN5);
    gen3p       = generation >= GEN3;
    is_com      = (RxData[7:0] == COM_SYMBOL) && RxDataK[0];
    accept      = RxValid && gen_ok && (!gen3p || RxDataValid);
    realign     = accept && (gen3p ? RxStartBlock : is_com);
    flush       = !RxValid || !gen_ok || (generation != gen_q);
    sb_beat     = realign && gen3p;
    align_err_d = realign && !flush && (beat_cnt != 2'd0);
    sync_hdr_d  = sb_beat ? RxSyncHeader : sync_hdr_q;
    word_sb     = sb_beat || (sb_pend_q && !flush && !realign);
    if (word_done)            sb_pend_d = 1'b0;
    else if (sb_beat)         sb_pend_d = 1'b1;
    else if (flush || realign) sb_pend_d = 1'b0;
    else                      sb_pend_d = sb_pend_q;
  end

  pipe_rx_byte_packer u_packer (
    .pclk        (pclk),
    .reset       (reset),
    .flush_i     (flush),
    .realign_i   (realign),
    .accept_i    (accept),
    .last_beat_i (last_beat),
    .data_i      (RxData),
    .k_i         (RxDataK),
    .word_done_o (word_done),
    .word_o      (word),
    .word_k_o    (word_k),
    .beat_cnt_o  (beat_cnt)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      gen_q         <= 3'd0;
      sync_hdr_q    <= 2'd0;
      sb_pend_q     <= 1'b0;
      data_q        <= 32'd0;
      data_k_q      <= 4'd0;
      valid_q       <= 1'b0;
      start_block_q <= 1'b0;
      sync_out_q    <= 2'd0;
      align_err_q   <= 1'b0;
    end else begin
      gen_q         <= generation;
      sync_hdr_q    <= sync_hdr_d;
      sb_pend_q     <= sb_pend_d;
      valid_q       <= word_done;
      start_block_q <= word_done && word_sb;
      align_err_q   <= align_err_d;
      if (word_done) begin
        data_q     <= word;
        data_k_q   <= word_k;
        sync_out_q <= sync_hdr_d;
      end
    end
  end

  assign descramblerDataIn     = data_q;
  assign descramblerDataK      = data_k_q;
  assign descramblerDataValid  = valid_q;
  assign descramblerStartBlock = start_block_q;
  assign descramblerSyncHeader = sync_out_q;
  assign alignErr              = align_err_q;

endmodule

// File: tb/tb_pipe_rx_data.sv
// Bench for pipe_rx_data: directed scenarios plus randomized streams, checked
// each cycle against a byte-queue reference model.
module tb_pipe_rx_data;

  logic        pclk = 1'b0;
  logic        reset;
  logic [2:0]  generation;
  logic [31:0] RxData;
  logic [3:0]  RxDataK;
  logic        RxValid, RxDataValid, RxStartBlock;
  logic [1:0]  RxSyncHeader;
  logic [31:0] descramblerDataIn;
  logic [3:0]  descramblerDataK;
  logic        descramblerDataValid, descramblerStartBlock, alignErr;
  logic [1:0]  descramblerSyncHeader;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [2:0]  m_gen_q;
  logic [8:0]  byte_q[$];
  logic        m_sb_pend;
  logic [1:0]  m_sh_store;
  logic        m_valid, m_sb, m_err;
  logic [31:0] m_data;
  logic [3:0]  m_k;
  logic [1:0]  m_sh;
  logic [31:0] exp_q[$];

  pipe_rx_data dut (
    .pclk                  (pclk),
    .reset                 (reset),
    .generation            (generation),
    .RxData                (RxData),
    .RxDataK               (RxDataK),
    .RxValid               (RxValid),
    .RxDataValid           (RxDataValid),
    .RxStartBlock          (RxStartBlock),
    .RxSyncHeader          (RxSyncHeader),
    .descramblerDataIn     (descramblerDataIn),
    .descramblerDataK      (descramblerDataK),
    .descramblerDataValid  (descramblerDataValid),
    .descramblerStartBlock (descramblerStartBlock),
    .descramblerSyncHeader (descramblerSyncHeader),
    .alignErr              (alignErr)
  );

  always #5 pclk = ~pclk;

  function automatic int width_of(input logic [2:0] g);
    case (g)
      3'd1, 3'd2: return 8;
      3'd3:       return 16;
      default:    return 32;
    endcase
  endfunction

  function automatic void model_reset();
    m_gen_q = 3'd0; byte_q.delete(); exp_q.delete();
    m_sb_pend = 1'b0; m_sh_store = 2'd0;
    m_valid = 1'b0; m_sb = 1'b0; m_err = 1'b0;
    m_data = 32'd0; m_k = 4'd0; m_sh = 2'd0;
  endfunction

  // Evaluates what the outputs must show after the coming rising edge.
  function automatic void model_step();
    bit gen_ok, gen3p, acc, realign, flush;
    int w;
    gen_ok  = generation >= 3'd1 && generation <= 3'd5;
    gen3p   = generation >= 3'd3;
    w       = width_of(generation);
    acc     = RxValid && gen_ok && (!gen3p || RxDataValid);
    realign = acc && (gen3p ? RxStartBlock : (RxData[7:0] == 8'hBC && RxDataK[0]));
    flush   = !RxValid || !gen_ok || (generation != m_gen_q);
    m_valid = 1'b0; m_sb = 1'b0;
    m_err   = realign && !flush && byte_q.size() != 0;
    if (flush) begin
      byte_q.delete();
      m_sb_pend = 1'b0;
    end
    if (realign) begin
      byte_q.delete();
      m_sb_pend = gen3p;
      if (gen3p) m_sh_store = RxSyncHeader;
    end
    if (acc) begin
      for (int i = 0; i < w / 8; i++) byte_q.push_back({RxDataK[i], RxData[8*i +: 8]});
      if (byte_q.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          m_data[8*i +: 8] = byte_q[i][7:0];
          m_k[i]           = byte_q[i][8];
        end
        m_valid = 1'b1;
        m_sb = m_sb_pend;
        m_sh = m_sh_store;
        m_sb_pend = 1'b0;
        byte_q.delete();
        exp_q.push_back(m_data);
      end
    end
    m_gen_q = generation;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    chk("valid", 32'(descramblerDataValid), 32'(m_valid));
    chk("align_err", 32'(alignErr), 32'(m_err));
    chk("data", descramblerDataIn, m_data);
    chk("data_k", 32'(descramblerDataK), 32'(m_k));
    chk("sync_hdr", 32'(descramblerSyncHeader), 32'(m_sh));
    chk("start_block", 32'(descramblerStartBlock), 32'(m_sb));
    if (descramblerDataValid === 1'b1 && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("scoreboard_word", descramblerDataIn, w);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge pclk);
    #1;
    check_outputs();
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k = 4'd0, input logic dv = 1'b1,
                      input logic sb = 1'b0, input logic [1:0] sh = 2'd0, input logic v = 1'b1);
    RxData = d; RxDataK = k; RxDataValid = dv; RxStartBlock = sb; RxSyncHeader = sh; RxValid = v;
    tick();
  endtask

  task automatic set_gen(input logic [2:0] g);
    generation = g;
    beat(32'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, descramblerDataIn, 32'd0);
    chk({tag, "_ctl"}, {25'd0, descramblerDataK, descramblerDataValid, descramblerStartBlock, alignErr},
        32'd0);
    chk({tag, "_sh"}, 32'(descramblerSyncHeader), 32'd0);
  endtask

  initial begin
    reset = 1'b1; generation = 3'd1; RxData = 32'd0; RxDataK = 4'd0;
    RxValid = 1'b0; RxDataValid = 1'b0; RxStartBlock = 1'b0; RxSyncHeader = 2'd0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Gen1 byte packing
    set_gen(3'd1);
    beat(32'h11); beat(32'h22); beat(32'h33);
    chk("gen1_no_early_pulse", 32'(descramblerDataValid), 32'd0);
    beat(32'h44);
    chk("gen1_word", descramblerDataIn, 32'h44332211);
    chk("gen1_pulse", 32'(descramblerDataValid), 32'd1);
    chk("gen1_k", 32'(descramblerDataK), 32'd0);

    // Gen3 block start and subsequent word
    set_gen(3'd3);
    beat(32'hAABB, 4'd0, 1'b1, 1'b1, 2'b10);
    beat(32'hCCDD);
    chk("gen3_word", descramblerDataIn, 32'hCCDDAABB);
    chk("gen3_sb", 32'(descramblerStartBlock), 32'd1);
    chk("gen3_sh", 32'(descramblerSyncHeader), 32'(2'b10));
    beat(32'h1111); beat(32'h2222);
    chk("gen3_next_sb", 32'(descramblerStartBlock), 32'd0);
    chk("gen3_next_valid", 32'(descramblerDataValid), 32'd1);

    // Gen3 with a skipped beat
    beat(32'h3344, 4'd0, 1'b1, 1'b1, 2'b01);
    beat(32'h9999, 4'd0, 1'b0);
    chk("gen3_skip_no_pulse", 32'(descramblerDataValid), 32'd0);
    beat(32'h5566);
    chk("gen3_skip_word", descramblerDataIn, 32'h55663344);

    // Gen1 COM realign
    set_gen(3'd1);
    beat(32'h01); beat(32'h02);
    beat(32'hBC, 4'd1);
    chk("com_align_err", 32'(alignErr), 32'd1);
    beat(32'h03); beat(32'h04); beat(32'h05);
    chk("com_word", descramblerDataIn, 32'h050403BC);
    chk("com_k", 32'(descramblerDataK), 32'h1);

    // Gen4 lock loss, then move to Gen2
    set_gen(3'd4);
    beat(32'hDEADBEEF);
    beat(32'h0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("gen4_drop_no_pulse", 32'(descramblerDataValid), 32'd0);
    set_gen(3'd2);
    chk("gen_change_no_err", 32'(alignErr), 32'd0);
    beat(32'hA1); beat(32'hA2); beat(32'hA3); beat(32'hA4);
    chk("gen2_word", descramblerDataIn, 32'hA4A3A2A1);

    // Reset mid-word at Gen2
    beat(32'h55); beat(32'h66);
    reset = 1'b1;
    #2;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge pclk);
    #1;
    reset = 1'b0;
    set_gen(3'd2);
    beat(32'h71); beat(32'h72); beat(32'h73); beat(32'h74);
    chk("post_reset_word", descramblerDataIn, 32'h74737271);

    // Randomized streams across generations, including invalid codes
    for (int ph = 0; ph < 40; ph++) begin
      int g;
      g = $urandom_range(0, 11);
      set_gen(g < 10 ? 3'(g % 5 + 1) : (g == 10 ? 3'd0 : 3'd7));
      for (int b = 0; b < 25; b++) begin
        logic [31:0] d;
        logic [3:0]  k;
        d = $urandom;
        k = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
        if (generation <= 3'd2 && $urandom_range(0, 9) == 0) begin
          d[7:0] = 8'hBC; k[0] = 1'b1;
        end
        beat(d, k, $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0,
             $urandom_range(0, 1) ? 2'b10 : 2'b01, $urandom_range(0, 19) != 0);
      end
    end

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
